// File: rtl/alu_seq_pkg.sv
// Shared widths, command record and FSM state encoding for the ALU command sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int MODE_W = 3;
  localparam int CMD_W  = 2 * DATA_W + MODE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [MODE_W-1:0] mode;
  } cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Command queue: power-of-two circular buffer with a head that is readable
// without popping. Full/empty come straight from the occupancy count.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("alu_seq_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only slots behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: queues commands, issues them one at a time to an
// external ALU, and holds each result until the consumer takes it.
// Optional macro ALU_SEQ_TIMEOUT_EN adds a WAIT watchdog that aborts an
// operation after TIMEOUT cycles and flags the response with rsp_timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no operation outstanding; pop head when queue non-empty
// ST_ISSUE | alu_start high for this one cycle
// ST_WAIT  | operands held on alu_*, waiting for alu_done
// ST_HOLD  | response held on rsp_* until rsp_ready
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_mode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_mode,
  output logic        alu_start,
  input  logic [7:0]  alu_op1,
  input  logic [7:0]  alu_op2,
  input  logic [15:0] alu_op3,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_op1,
  output logic [7:0]  rsp_op2,
  output logic [15:0] rsp_op3,
  output logic [2:0]  rsp_mode,
  output logic        rsp_timeout
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("alu_cmd_sequencer: TIMEOUT must be at least 1");
  end

  state_t state;
  cmd_t   push_cmd;
  cmd_t   head_cmd;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;

  assign push_cmd  = {cmd_a, cmd_b, cmd_mode};
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .wdata (push_cmd),
    .pop   (fifo_pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_flag;

  assign rsp_timeout = tmo_flag;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Sequencer FSM; every ALU- and response-facing output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_mode  <= '0;
      alu_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_op1   <= '0;
      rsp_op2   <= '0;
      rsp_op3   <= '0;
      rsp_mode  <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_cnt   <= '0;
      tmo_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a     <= head_cmd.a;
            alu_b     <= head_cmd.b;
            alu_mode  <= head_cmd.mode;
            alu_start <= 1'b1;
            state     <= ST_ISSUE;
`ifdef ALU_SEQ_TIMEOUT_EN
            tmo_cnt   <= TMO_LOAD;
`endif
          end
        end
        ST_ISSUE: begin
          alu_start <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done takes priority over an expiring watchdog on the same edge.
          if (alu_done) begin
            rsp_op1   <= alu_op1;
            rsp_op2   <= alu_op2;
            rsp_op3   <= alu_op3;
            rsp_mode  <= alu_mode;
            rsp_valid <= 1'b1;
            state     <= ST_HOLD;
`ifdef ALU_SEQ_TIMEOUT_EN
            tmo_flag  <= 1'b0;
          end else if (tmo_cnt == '0) begin
            rsp_op1   <= '0;
            rsp_op2   <= '0;
            rsp_op3   <= '0;
            rsp_mode  <= alu_mode;
            rsp_valid <= 1'b1;
            tmo_flag  <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            tmo_cnt   <= tmo_cnt - 1'b1;
`endif
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus a
// randomized run scored against a queue-based reference model and bench ALU.
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_mode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_mode;
  logic        alu_start;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic [15:0] alu_op3;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_op1;
  logic [7:0]  rsp_op2;
  logic [15:0] rsp_op3;
  logic [2:0]  rsp_mode;
  logic        rsp_timeout;

  alu_cmd_sequencer #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_mode    (cmd_mode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_mode    (alu_mode),
    .alu_start   (alu_start),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_op3     (alu_op3),
    .alu_done    (alu_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_op1     (rsp_op1),
    .rsp_op2     (rsp_op2),
    .rsp_op3     (rsp_op3),
    .rsp_mode    (rsp_mode),
    .rsp_timeout (rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] mode;
  } cmd_s;

  typedef struct packed {
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [15:0] op3;
    logic [2:0]  mode;
  } rsp_s;

  int   checks = 0;
  int   errors = 0;
  cmd_s exp_q[$];
  rsp_s rsp_q[$];
  bit   alu_busy = 1'b0;
  int   alu_n = 0;
  int   alu_delay = 1;
  cmd_s alu_cur;
  int   rsp_policy = 0;
  int   n_acc = 0;
  int   n_rsp = 0;

  // Bench ALU: sum, xor and full product of the operands.
  function automatic rsp_s alu_model(cmd_s c);
    rsp_s r;
    r.op1  = c.a + c.b;
    r.op2  = c.a ^ c.b;
    r.op3  = c.a * c.b;
    r.mode = c.mode;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of the model-driven environment: ALU responder, response sink,
  // command acceptance bookkeeping, then advance and observe issues.
  task automatic step();
    cmd_s c;
    rsp_s r;
    alu_done = 1'b0;
    if (alu_busy && alu_n == alu_delay) begin
      r        = alu_model(alu_cur);
      alu_op1  = r.op1;
      alu_op2  = r.op2;
      alu_op3  = r.op3;
      alu_done = 1'b1;
      rsp_q.push_back(r);
      alu_busy = 1'b0;
    end
    case (rsp_policy)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    if (cmd_valid && cmd_ready) begin
      exp_q.push_back({cmd_a, cmd_b, cmd_mode});
      n_acc++;
    end
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got response op3=%h, expected none", rsp_op3);
      end else begin
        r = rsp_q.pop_front();
        if ({rsp_op1, rsp_op2, rsp_op3, rsp_mode, rsp_timeout} !== {r, 1'b0}) begin
          errors++;
          $display("FAIL rsp_data: got %h/%h/%h/%h to=%b, expected %h/%h/%h/%h to=0",
                   rsp_op1, rsp_op2, rsp_op3, rsp_mode, rsp_timeout, r.op1, r.op2, r.op3, r.mode);
        end
      end
      n_rsp++;
    end
    tick();
    alu_done = 1'b0;
    if (alu_start) begin
      checks++;
      if (alu_busy || exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: alu_start with busy=%0d queued=%0d, expected idle ALU and queued cmd",
                 alu_busy, exp_q.size());
      end else begin
        c = exp_q.pop_front();
        alu_cur = c;
        if ({alu_a, alu_b, alu_mode} !== c) begin
          errors++;
          $display("FAIL issue_operands: got %h/%h/%h, expected %h/%h/%h",
                   alu_a, alu_b, alu_mode, c.a, c.b, c.mode);
        end
      end
      alu_busy  = 1'b1;
      alu_n     = 0;
      alu_delay = $urandom_range(1, 4);
    end else if (alu_busy) begin
      alu_n++;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    cmd_valid  = 1'b0;
    rsp_policy = 1;
    while (!(exp_q.size() == 0 && rsp_q.size() == 0 && !alu_busy && !rsp_valid) && guard < 400) begin
      step();
      guard++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cmds and %0d rsps outstanding, expected 0",
               exp_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_mode = '0;
    alu_op1 = '0; alu_op2 = '0; alu_op3 = '0; alu_done = 1'b0; rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({alu_a, alu_b, alu_mode, alu_start, rsp_valid, rsp_op1, rsp_op2, rsp_op3, rsp_mode, rsp_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs a=%h start=%b rv=%b op3=%h, expected all 0",
               alu_a, alu_start, rsp_valid, rsp_op3);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || alu_start !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_exit: got ready=%b start=%b rv=%b, expected 1/0/0", cmd_ready, alu_start, rsp_valid);
    end
  endtask

  task automatic test_single_op();
    cmd_valid = 1'b1; cmd_a = 8'h03; cmd_b = 8'h02; cmd_mode = 3'b100;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_start !== 1'b0) begin
      errors++;
      $display("FAIL single_early_start: got alu_start=%b at E, expected 0", alu_start);
    end
    tick();
    checks++;
    if (alu_start !== 1'b1 || {alu_a, alu_b, alu_mode} !== {8'h03, 8'h02, 3'b100}) begin
      errors++;
      $display("FAIL single_issue: got start=%b a=%h b=%h m=%b, expected 1/03/02/100",
               alu_start, alu_a, alu_b, alu_mode);
    end
    tick();
    tick();
    checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: got start=%b rv=%b, expected 0/0", alu_start, rsp_valid);
    end
    alu_done = 1'b1; alu_op1 = 8'h05; alu_op2 = 8'h01; alu_op3 = 16'h0006;
    tick();
    alu_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_op3 !== 16'h0006 || rsp_mode !== 3'b100 || rsp_op1 !== 8'h05) begin
      errors++;
      $display("FAIL single_rsp: got rv=%b op3=%h mode=%b op1=%h, expected 1/0006/100/05",
               rsp_valid, rsp_op3, rsp_mode, rsp_op1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: got rsp_valid=%b after handshake, expected 0", rsp_valid);
    end
  endtask

  task automatic test_stray_done();
    bit seen;
    seen = 1'b0;
    alu_done = 1'b1; alu_op1 = 8'hAA; alu_op2 = 8'hBB; alu_op3 = 16'hCCCC;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL stray_idle: got rsp_valid=1 from done in IDLE, expected 0");
    end
    cmd_valid = 1'b1; cmd_a = 8'h10; cmd_b = 8'h20; cmd_mode = 3'b011;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    alu_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_issue: got rsp_valid=%b after done during ISSUE, expected 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_wait: got rsp_valid=%b without done, expected 0", rsp_valid);
    end
    alu_done = 1'b1; alu_op3 = 16'h1234;
    tick();
    alu_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_op3 !== 16'h1234 || rsp_mode !== 3'b011) begin
      errors++;
      $display("FAIL stray_capture: got rv=%b op3=%h mode=%b, expected 1/1234/011", rsp_valid, rsp_op3, rsp_mode);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit bad;
    bad = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'h41; cmd_b = 8'h42; cmd_mode = 3'b001;
    tick();
    cmd_a = 8'h51; cmd_b = 8'h52; cmd_mode = 3'b110;
    tick();
    cmd_valid = 1'b0;
    tick();
    alu_done = 1'b1; alu_op1 = 8'h11; alu_op2 = 8'h22; alu_op3 = 16'h00A1;
    tick();
    alu_done = 1'b0; alu_op1 = 8'h00; alu_op2 = 8'h00; alu_op3 = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_op3 !== 16'h00A1 || rsp_op1 !== 8'h11 || rsp_mode !== 3'b001 || alu_start !== 1'b0)
        bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got rv=%b op3=%h start=%b, expected 1/00A1/0 throughout", rsp_valid, rsp_op3, alu_start);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got start=%b rv=%b, expected 0/0", alu_start, rsp_valid);
    end
    tick();
    checks++;
    if (alu_start !== 1'b1 || alu_a !== 8'h51 || alu_mode !== 3'b110) begin
      errors++;
      $display("FAIL bp_next_issue: got start=%b a=%h mode=%b, expected 1/51/110", alu_start, alu_a, alu_mode);
    end
    tick();
    alu_done = 1'b1; alu_op3 = 16'h00B2;
    tick();
    alu_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_op3 !== 16'h00B2 || rsp_mode !== 3'b110) begin
      errors++;
      $display("FAIL bp_second_rsp: got rv=%b op3=%h mode=%b, expected 1/00B2/110", rsp_valid, rsp_op3, rsp_mode);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_mode = 3'b101;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got rsp_valid=%b after 7 WAIT cycles, expected 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || {rsp_op1, rsp_op2, rsp_op3} !== 32'h0 || rsp_mode !== 3'b101) begin
      errors++;
      $display("FAIL tmo_abort: got rv=%b to=%b op3=%h mode=%b, expected 1/1/0000/101",
               rsp_valid, rsp_timeout, rsp_op3, rsp_mode);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'h33; cmd_b = 8'h44; cmd_mode = 3'b010;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    alu_done = 1'b1; alu_op3 = 16'hBEEF;
    tick();
    alu_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_op3 !== 16'hBEEF) begin
      errors++;
      $display("FAIL tmo_done_wins: got rv=%b to=%b op3=%h, expected 1/0/BEEF", rsp_valid, rsp_timeout, rsp_op3);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    bit seen;
    seen = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_mode = 3'b101;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL notmo_wait: got response without done, expected none");
    end
    alu_done = 1'b1; alu_op3 = 16'h0042;
    tick();
    alu_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_op3 !== 16'h0042 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL notmo_done: got rv=%b op3=%h to=%b, expected 1/0042/0", rsp_valid, rsp_op3, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_full_fifo();
    int acc0;
    int rsp0;
    bit bad;
    bad  = 1'b0;
    acc0 = n_acc;
    rsp0 = n_rsp;
    rsp_policy = 0;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_mode = 3'($urandom_range(0, 7));
      step();
    end
    checks++;
    if (n_acc - acc0 !== 5 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_fill: got %0d accepted, ready=%b, expected 5 accepted, ready=0", n_acc - acc0, cmd_ready);
    end
    cmd_a = 8'hEE; cmd_b = 8'hEF; cmd_mode = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cmd_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || n_acc - acc0 !== 5) begin
      errors++;
      $display("FAIL full_stall: got %0d accepted, expected 5 with ready held 0", n_acc - acc0);
    end
    drain();
    checks++;
    if (n_rsp - rsp0 !== 5) begin
      errors++;
      $display("FAIL full_drain: got %0d responses, expected 5", n_rsp - rsp0);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    seen = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'h81; cmd_b = 8'h82; cmd_mode = 3'b111;
    tick();
    cmd_a = 8'h91;
    tick();
    cmd_a = 8'hA1;
    tick();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({alu_a, alu_b, alu_mode, alu_start, rsp_valid, rsp_op1, rsp_op2, rsp_op3, rsp_mode, rsp_timeout} !== '0) begin
      errors++;
      $display("FAIL rstwait_outputs: got a=%h start=%b rv=%b, expected all 0", alu_a, alu_start, rsp_valid);
    end
    rst_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_ready: got cmd_ready=%b, expected 1", cmd_ready);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      alu_done = 1'($urandom_range(0, 1));
      alu_op3  = 16'($urandom);
      tick();
      if (alu_start !== 1'b0 || rsp_valid !== 1'b0) seen = 1'b1;
    end
    alu_done  = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstwait_ghost: got issue or response after reset, expected none");
    end
  endtask

  task automatic test_random();
    int acc0;
    int rsp0;
    acc0 = n_acc;
    rsp0 = n_rsp;
    rsp_policy = 2;
    for (int i = 0; i < 300; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_mode  = 3'($urandom_range(0, 7));
      step();
    end
    drain();
    checks++;
    if (n_rsp - rsp0 !== n_acc - acc0 || n_acc - acc0 < 10) begin
      errors++;
      $display("FAIL random_count: got %0d responses for %0d commands, expected equal and >=10",
               n_rsp - rsp0, n_acc - acc0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_op();
    test_stray_done();
    test_backpressure();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_full_fifo();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
